// File: rtl/multi_operand_sum_pkg.sv
// Shared helpers for the N-operand streaming adder: pointer width, wide-sum width,
// and the operand element type carried on each up_data lane.
package multi_operand_sum_pkg;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Width needed to hold the exact sum of n_inputs operands of the given width.
  function automatic int unsigned sum_w(input int unsigned width, input int unsigned n_inputs);
    return width + $clog2(n_inputs);
  endfunction

  localparam int unsigned DEF_WIDTH = 4;

  typedef logic [DEF_WIDTH-1:0] operand_t;

endpackage

// File: rtl/multi_operand_sum_using_fifos_fifo.sv
// Flip-flop FIFO with an extra pointer bit to tell full from empty.
module flip_flop_fifo
  import multi_operand_sum_pkg::*;
#(
  parameter int unsigned width = 4,
  parameter int unsigned depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] write_data,
  output logic [width-1:0] read_data,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = ptr_w(depth);

  logic [PW:0]      r_wr;
  logic [PW:0]      r_rd;
  logic [width-1:0] r_mem [depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (push && !full) r_wr <= r_wr + (PW+1)'(1);
      if (pop && !empty) r_rd <= r_rd + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) r_mem[r_wr[PW-1:0]] <= write_data;
  end

  assign read_data = r_mem[r_rd[PW-1:0]];
  assign empty     = (r_wr == r_rd);
  assign full      = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);

endmodule

// File: rtl/multi_operand_sum_using_fifos.sv
// N-operand streaming adder: per-channel FIFOs joined into one registered sum.
// Define MULTI_OPERAND_SUM_SATURATE_EN for unsigned saturation instead of modulo wrap.
module multi_operand_sum_using_fifos
  import multi_operand_sum_pkg::*;
#(
  parameter int unsigned n_inputs = 3,
  parameter int unsigned width    = 4,
  parameter int unsigned depth    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [n_inputs-1:0]       up_valid,
  output logic [n_inputs-1:0]       up_ready,
  input  logic [n_inputs*width-1:0] up_data,
  output logic                      sum_valid,
  input  logic                      sum_ready,
  output logic [width-1:0]          sum_data
);

  logic [n_inputs-1:0] w_empty;
  logic [n_inputs-1:0] w_full;
  logic [n_inputs-1:0] w_push;
  logic [width-1:0]    w_head [n_inputs];
  logic                w_all_ne;
  logic                w_out_free;
  logic                w_pop;
  logic [width-1:0]    w_sum;

  logic                r_valid;
  logic [width-1:0]    r_data;

  genvar g;
  for (g = 0; g < n_inputs; g++) begin : g_chan
    assign w_push[g] = up_valid[g] & ~w_full[g];

    flip_flop_fifo #(
      .width (width),
      .depth (depth)
    ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (w_push[g]),
      .pop        (w_pop),
      .write_data (up_data[g*width +: width]),
      .read_data  (w_head[g]),
      .empty      (w_empty[g]),
      .full       (w_full[g])
    );
  end

  assign up_ready   = ~w_full;
  assign w_all_ne   = ~|w_empty;
  assign w_out_free = ~r_valid | sum_ready;
  assign w_pop      = w_all_ne & w_out_free;

`ifdef MULTI_OPERAND_SUM_SATURATE_EN
  localparam int unsigned SW = sum_w(width, n_inputs);
  logic [SW-1:0] w_wide;

  always_comb begin
    w_wide = '0;
    for (int unsigned i = 0; i < n_inputs; i++) w_wide = w_wide + SW'(w_head[i]);
    w_sum = (w_wide[SW-1:width] != '0) ? '1 : w_wide[width-1:0];
  end
`else
  always_comb begin
    w_sum = '0;
    for (int unsigned i = 0; i < n_inputs; i++) w_sum = w_sum + w_head[i];
  end
`endif

  // Data is only reloaded on pop, so it stays stable across backpressure and after drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_data  <= w_sum;
    end else if (sum_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign sum_valid = r_valid;
  assign sum_data  = r_data;

endmodule

// File: tb/tb_multi_operand_sum_using_fifos.sv
// Scoreboard bench for multi_operand_sum_using_fifos (n_inputs=3, width=4, depth=4).
`timescale 1ns/1ps
module tb_multi_operand_sum_using_fifos;
  import multi_operand_sum_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  up_valid = '0;
  logic [2:0]  up_ready;
  logic [11:0] up_data = '0;
  logic        sum_valid;
  logic        sum_ready = 1'b0;
  logic [3:0]  sum_data;

  int unsigned n_cmp  = 0;
  int unsigned n_err  = 0;
  int unsigned n_sums = 0;
  int unsigned exp_q[$];
  logic        hold_pend = 1'b0;
  logic [3:0]  hold_data = '0;

  always #5 clk = ~clk;

  multi_operand_sum_using_fifos #(
    .n_inputs (3),
    .width    (4),
    .depth    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_data   (up_data),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] v, input operand_t d0, input operand_t d1, input operand_t d2);
    up_valid = v;
    up_data  = {d2, d1, d0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every downstream handshake against the scoreboard and
  // checks that a stalled sum is held stable.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          check("hold_valid", 32'(sum_valid), 32'(1));
          check("hold_data", 32'(sum_data), 32'(hold_data));
        end
        hold_pend = sum_valid & ~sum_ready;
        hold_data = sum_data;
        if (sum_valid && sum_ready) begin
          n_sums++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_sum: got %0d, required no sum (t=%0t)", sum_data, $time);
          end else begin
            check("sum_data", 32'(sum_data), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    int unsigned base;
    int unsigned acc [3];

    // Reset
    rst = 1'b1;
    drive(3'b000, 0, 0, 0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(sum_valid), 32'(0));
      check("rst_data", 32'(sum_data), 32'(0));
      check("rst_ready", 32'(up_ready), 32'(7));
    end
    @(posedge clk);
    #1 rst = 1'b0;

    // Back-to-back streaming
    base = n_sums;
    sum_ready = 1'b1;
    drive(3'b111, 1, 2, 3);
    repeat (20) exp_q.push_back(6);
    for (int c = 0; c < 22; c++) begin
      @(posedge clk);
      #1;
      if (c == 19) drive(3'b000, 0, 0, 0);
      @(negedge clk);
      check("b2b_valid", 32'(sum_valid), (c >= 1 && c <= 20) ? 32'(1) : 32'(0));
      check("b2b_ready", 32'(up_ready), 32'(7));
    end
    check("b2b_count", n_sums - base, 32'(20));
    check("b2b_q_empty", 32'(exp_q.size()), 32'(0));

    // Starved channel 2
    step();
    base = n_sums;
    for (int c = 0; c < 6; c++) begin
      drive(3'b011, operand_t'(c + 1), operand_t'(c + 5), 0);
      @(negedge clk);
      check("starve_ready", 32'(up_ready), (c < 4) ? 32'(7) : 32'(4));
      check("starve_valid", 32'(sum_valid), 32'(0));
      step();
    end
    drive(3'b000, 0, 0, 0);
    exp_q.push_back(6);
    exp_q.push_back(9);
    exp_q.push_back(12);
    exp_q.push_back(15);
    for (int c = 0; c < 4; c++) begin
      drive(3'b100, 0, 0, operand_t'(c));
      @(negedge clk);
      check("ch2_ready", 32'(up_ready[2]), 32'(1));
      step();
    end
    drive(3'b000, 0, 0, 0);
    repeat (8) step();
    check("starve_count", n_sums - base, 32'(4));
    check("starve_q_empty", 32'(exp_q.size()), 32'(0));

    // Backpressure: five operands per channel fit (four queued plus one sum held)
    base = n_sums;
    sum_ready = 1'b0;
    acc = '{0, 0, 0};
    for (int c = 0; c < 5; c++) exp_q.push_back(c + 3);
    for (int c = 0; c < 20; c++) begin
      drive(3'b111, operand_t'(c), 1, 2);
      @(negedge clk);
      check("bp_ready", 32'(up_ready), (c < 5) ? 32'(7) : 32'(0));
      check("bp_valid", 32'(sum_valid), (c >= 2) ? 32'(1) : 32'(0));
      for (int i = 0; i < 3; i++) if (up_valid[i] && up_ready[i]) acc[i]++;
      step();
    end
    for (int i = 0; i < 3; i++) check("bp_pushes", acc[i], 32'(5));
    drive(3'b000, 0, 0, 0);
    sum_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("drain_valid", 32'(sum_valid), (k < 5) ? 32'(1) : 32'(0));
      step();
    end
    check("drain_count", n_sums - base, 32'(5));
    check("drain_q_empty", 32'(exp_q.size()), 32'(0));

    // Overflow
`ifdef MULTI_OPERAND_SUM_SATURATE_EN
    exp_q.push_back(15);
`else
    exp_q.push_back(8);
`endif
    drive(3'b111, 7, 8, 9);
    step();
    drive(3'b000, 0, 0, 0);
    repeat (4) step();
    check("ovf_q_empty", 32'(exp_q.size()), 32'(0));

    // Reset mid-operation with FIFOs at 2/3/1 and a sum pending
    base = n_sums;
    sum_ready = 1'b0;
    drive(3'b111, 5, 5, 5);
    step();
    drive(3'b111, 5, 5, 5);
    step();
    drive(3'b011, 5, 5, 5);
    step();
    drive(3'b010, 5, 5, 5);
    step();
    @(negedge clk);
    check("pre_rst_valid", 32'(sum_valid), 32'(1));
    check("pre_rst_ready", 32'(up_ready), 32'(7));
    rst = 1'b1;
    drive(3'b000, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    check("midrst_valid", 32'(sum_valid), 32'(0));
    check("midrst_data", 32'(sum_data), 32'(0));
    check("midrst_ready", 32'(up_ready), 32'(7));
    @(posedge clk);
    #1 rst = 1'b0;
    sum_ready = 1'b1;
    exp_q.push_back(3);
    drive(3'b111, 1, 1, 1);
    step();
    drive(3'b000, 0, 0, 0);
    repeat (6) step();
    check("restart_count", n_sums - base, 32'(1));
    check("restart_q_empty", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
